// File: rtl/node_port_pkg.sv
// Shared types and constants for the processor-side node endpoint.
// Packet layout: {dest[3:0], ctl, payload[23:0]}.
package node_port_pkg;

    localparam int unsigned NODE_ADDR_W = 4;
    localparam int unsigned PAYLOAD_W   = 24;
    localparam int unsigned NODE_PKT_W  = NODE_ADDR_W + 1 + PAYLOAD_W;

    localparam int unsigned DEST_MSB    = NODE_PKT_W - 1;
    localparam int unsigned DEST_LSB    = PAYLOAD_W + 1;
    localparam int unsigned CTL_BIT     = PAYLOAD_W;
    localparam int unsigned PAYLOAD_MSB = PAYLOAD_W - 1;
    localparam int unsigned PAYLOAD_LSB = 0;

    typedef logic [NODE_PKT_W-1:0]  node_pkt_t;
    typedef logic [PAYLOAD_W-1:0]   payload_t;
    typedef logic [NODE_ADDR_W-1:0] node_addr_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OFFER,
        ST_WAIT_LOW
    } offer_state_t;

    function automatic node_pkt_t make_pkt(input node_addr_t dest,
                                           input logic       ctl,
                                           input payload_t   payload);
        return {dest, ctl, payload};
    endfunction

    function automatic payload_t pkt_payload(input node_pkt_t pkt);
        return pkt[PAYLOAD_MSB:PAYLOAD_LSB];
    endfunction

endpackage

// File: rtl/node_port_if.sv
// Handshake bundle between the processing element / router core and node_port.
// The slave modport is the node_port view; master is the environment view.
interface node_port_if;

    logic                           Pe_Wr_Valid;
    node_port_pkg::node_pkt_t       Pe_Wr_Data;
    logic                           Pe_Wr_Ready;

    logic                           Pe_Rd_Valid;
    node_port_pkg::payload_t        Pe_Rd_Data;
    logic                           Pe_Rd_Ready;

    node_port_pkg::node_pkt_t       Packet_From_Node;
    logic                           Packet_From_Node_Valid;
    logic                           Core_Load_Ack;

    node_port_pkg::payload_t        Packet_To_Node;
    logic                           Packet_To_Node_Valid;

    modport master (
        output Pe_Wr_Valid,
        output Pe_Wr_Data,
        input  Pe_Wr_Ready,
        input  Pe_Rd_Valid,
        input  Pe_Rd_Data,
        output Pe_Rd_Ready,
        input  Packet_From_Node,
        input  Packet_From_Node_Valid,
        output Core_Load_Ack,
        output Packet_To_Node,
        output Packet_To_Node_Valid
    );

    modport slave (
        input  Pe_Wr_Valid,
        input  Pe_Wr_Data,
        output Pe_Wr_Ready,
        output Pe_Rd_Valid,
        output Pe_Rd_Data,
        input  Pe_Rd_Ready,
        output Packet_From_Node,
        output Packet_From_Node_Valid,
        input  Core_Load_Ack,
        input  Packet_To_Node,
        input  Packet_To_Node_Valid
    );

endinterface

// File: rtl/node_fifo.sv
// Synchronous FIFO, power-of-two depth, with same-cycle push/pop.
// A push into a full FIFO is accepted only when a pop happens that cycle.
module node_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/node_port.sv
// Processor-side endpoint: buffers PE packets and offers them to the router
// core one at a time, and queues packets delivered by the core for the PE.
module node_port
    import node_port_pkg::*;
#(
    parameter int unsigned TX_DEPTH    = 4,
    parameter int unsigned RX_DEPTH    = 4,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        Clk_R,
    input  logic        Rst,
    node_port_if.slave  np,
    output logic        Tx_Timeout,
    output logic        Rx_Overflow,
    output logic [7:0]  Tx_Count,
    output logic [7:0]  Rx_Count
);

    offer_state_t state;
    offer_state_t state_nxt;

    node_pkt_t tx_head;
    logic      tx_full;
    logic      tx_empty;
    logic      tx_push;
    logic      tx_pop;
    logic      offer_valid;
    logic      timer_run;
    logic [7:0] ack_timer;

    payload_t  rx_head;
    logic      rx_full;
    logic      rx_empty;
    logic      rx_push;
    logic      rx_pop;
    logic      rx_valid_q;
    logic      rx_rise;
    logic      rx_drop;

    // Outbound path
    assign tx_push        = np.Pe_Wr_Valid && !tx_full;
    assign np.Pe_Wr_Ready = !tx_full;

    node_fifo #(
        .WIDTH (NODE_PKT_W),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk     (Clk_R),
        .rst     (Rst),
        .push    (tx_push),
        .wr_data (np.Pe_Wr_Data),
        .pop     (tx_pop),
        .rd_data (tx_head),
        .full    (tx_full),
        .empty   (tx_empty)
    );

    always_ff @(posedge Clk_R or posedge Rst) begin
        if (Rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:     if (!tx_empty)          state_nxt = ST_OFFER;
            ST_OFFER:    if (np.Core_Load_Ack)   state_nxt = ST_WAIT_LOW;
            ST_WAIT_LOW: if (!np.Core_Load_Ack)  state_nxt = ST_IDLE;
            default:                             state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        offer_valid = 1'b0;
        tx_pop      = 1'b0;
        timer_run   = 1'b0;
        if (state == ST_OFFER) begin
            offer_valid = 1'b1;
            tx_pop      = np.Core_Load_Ack;
            timer_run   = !np.Core_Load_Ack;
        end
    end

    // Data is forced to zero outside an offer so idle outputs read as 0
    assign np.Packet_From_Node_Valid = offer_valid;
    assign np.Packet_From_Node       = offer_valid ? tx_head : '0;

    always_ff @(posedge Clk_R or posedge Rst) begin
        if (Rst) begin
            Tx_Count   <= '0;
            ack_timer  <= '0;
            Tx_Timeout <= 1'b0;
        end else begin
            if (tx_pop) begin
                Tx_Count <= Tx_Count + 8'd1;
            end
            if (!timer_run) begin
                ack_timer <= '0;
            end else if (ack_timer != '1) begin
                ack_timer <= ack_timer + 8'd1;
            end
            if (timer_run && (({1'b0, ack_timer} + 9'd1) == 9'(ACK_TIMEOUT))) begin
                Tx_Timeout <= 1'b1;
            end
        end
    end

    // Inbound path: one packet per rising edge of the core's valid level
    assign rx_rise = np.Packet_To_Node_Valid && !rx_valid_q;
    assign rx_pop  = np.Pe_Rd_Ready && !rx_empty;
    assign rx_push = rx_rise && (!rx_full || rx_pop);
    assign rx_drop = rx_rise && rx_full && !rx_pop;

    node_fifo #(
        .WIDTH (PAYLOAD_W),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk     (Clk_R),
        .rst     (Rst),
        .push    (rx_push),
        .wr_data (np.Packet_To_Node),
        .pop     (rx_pop),
        .rd_data (rx_head),
        .full    (rx_full),
        .empty   (rx_empty)
    );

    assign np.Pe_Rd_Valid = !rx_empty;
    assign np.Pe_Rd_Data  = rx_empty ? '0 : rx_head;

    always_ff @(posedge Clk_R or posedge Rst) begin
        if (Rst) begin
            rx_valid_q  <= 1'b0;
            Rx_Count    <= '0;
            Rx_Overflow <= 1'b0;
        end else begin
            rx_valid_q <= np.Packet_To_Node_Valid;
            if (rx_push) begin
                Rx_Count <= Rx_Count + 8'd1;
            end
            if (rx_drop) begin
                Rx_Overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_node_port.sv
// Bench for node_port: vector table, directed corner sequences, and a
// randomized run against a queue-based reference model.
module tb_node_port;
    import node_port_pkg::*;

    localparam int unsigned TXD = 4;
    localparam int unsigned RXD = 4;
    localparam int unsigned TMO = 10;

    logic       clk;
    logic       rst;
    logic       tx_timeout;
    logic       rx_overflow;
    logic [7:0] tx_count;
    logic [7:0] rx_count;

    int n_vec = 0;
    int n_bad = 0;

    node_port_if bus();

    node_port #(
        .TX_DEPTH    (TXD),
        .RX_DEPTH    (RXD),
        .ACK_TIMEOUT (TMO)
    ) dut (
        .Clk_R       (clk),
        .Rst         (rst),
        .np          (bus.slave),
        .Tx_Timeout  (tx_timeout),
        .Rx_Overflow (rx_overflow),
        .Tx_Count    (tx_count),
        .Rx_Count    (rx_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       wv;
        node_pkt_t  wd;
        logic       ack;
        logic       pv;
        payload_t   pd;
        logic       rr;
        logic       e_val;
        node_pkt_t  e_pfn;
        logic       e_wrdy;
        logic       e_rdv;
        payload_t   e_rdd;
        logic [7:0] e_tc;
        logic [7:0] e_rc;
    } vec_t;

    function automatic vec_t mk(input logic wv, input node_pkt_t wd, input logic ack,
                                input logic pv, input payload_t pd, input logic rr,
                                input logic e_val, input node_pkt_t e_pfn, input logic e_wrdy,
                                input logic e_rdv, input payload_t e_rdd,
                                input logic [7:0] e_tc, input logic [7:0] e_rc);
        vec_t v;
        v.wv = wv; v.wd = wd; v.ack = ack; v.pv = pv; v.pd = pd; v.rr = rr;
        v.e_val = e_val; v.e_pfn = e_pfn; v.e_wrdy = e_wrdy;
        v.e_rdv = e_rdv; v.e_rdd = e_rdd; v.e_tc = e_tc; v.e_rc = e_rc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.Pe_Wr_Valid          = 1'b0;
        bus.Pe_Wr_Data           = '0;
        bus.Pe_Rd_Ready          = 1'b0;
        bus.Core_Load_Ack        = 1'b0;
        bus.Packet_To_Node       = '0;
        bus.Packet_To_Node_Valid = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic wait_offer(input string name);
        int c = 0;
        while (!bus.Packet_From_Node_Valid && c < 20) begin
            step();
            c++;
        end
        chk(name, 32'(bus.Packet_From_Node_Valid), 32'd1);
    endtask

    // Reference model state
    node_pkt_t  m_txq[$];
    payload_t   m_rxq[$];
    logic       m_offer, m_waitlow, m_prev, m_tmo, m_ovf;
    int         m_cycles;
    logic [7:0] m_tc, m_rc;

    task automatic model_reset();
        m_txq.delete();
        m_rxq.delete();
        m_offer = 0; m_waitlow = 0; m_prev = 0; m_tmo = 0; m_ovf = 0;
        m_cycles = 0; m_tc = '0; m_rc = '0;
    endtask

    task automatic model_compare(input int cyc);
        chk($sformatf("r%0d pfn_valid", cyc), 32'(bus.Packet_From_Node_Valid), 32'(m_offer));
        if (m_offer)
            chk($sformatf("r%0d pfn", cyc), 32'(bus.Packet_From_Node), 32'(m_txq[0]));
        chk($sformatf("r%0d wr_ready", cyc), 32'(bus.Pe_Wr_Ready), 32'(m_txq.size() < TXD));
        chk($sformatf("r%0d rd_valid", cyc), 32'(bus.Pe_Rd_Valid), 32'(m_rxq.size() > 0));
        if (m_rxq.size() > 0)
            chk($sformatf("r%0d rd_data", cyc), 32'(bus.Pe_Rd_Data), 32'(m_rxq[0]));
        chk($sformatf("r%0d tx_count", cyc), 32'(tx_count), 32'(m_tc));
        chk($sformatf("r%0d rx_count", cyc), 32'(rx_count), 32'(m_rc));
        chk($sformatf("r%0d tx_timeout", cyc), 32'(tx_timeout), 32'(m_tmo));
        chk($sformatf("r%0d rx_overflow", cyc), 32'(rx_overflow), 32'(m_ovf));
    endtask

    // Advance the model across one clock edge using the inputs now driven
    task automatic model_edge();
        logic had_pkt;
        logic wr, rd, rise;
        had_pkt = (m_txq.size() > 0);
        wr   = bus.Pe_Wr_Valid && (m_txq.size() < TXD);
        rd   = bus.Pe_Rd_Ready && (m_rxq.size() > 0);
        rise = bus.Packet_To_Node_Valid && !m_prev;
        if (m_offer) begin
            if (bus.Core_Load_Ack) begin
                void'(m_txq.pop_front());
                m_tc++;
                m_offer = 0;
                m_waitlow = 1;
                m_cycles = 0;
            end else begin
                m_cycles++;
                if (m_cycles >= int'(TMO)) m_tmo = 1;
            end
        end else if (m_waitlow) begin
            if (!bus.Core_Load_Ack) m_waitlow = 0;
        end else if (had_pkt) begin
            m_offer = 1;
        end
        if (wr) m_txq.push_back(bus.Pe_Wr_Data);
        if (rd) void'(m_rxq.pop_front());
        if (rise) begin
            if (m_rxq.size() < RXD) begin
                m_rxq.push_back(bus.Packet_To_Node);
                m_rc++;
            end else begin
                m_ovf = 1;
            end
        end
        m_prev = bus.Packet_To_Node_Valid;
    endtask

    vec_t tbl[13];

    initial begin
        node_pkt_t p42, p100, pk;

        p42  = make_pkt(4'd1, 1'b0, 24'd42);
        p100 = make_pkt(4'd1, 1'b0, 24'd100);

        //            wv wd   ack pv pd  rr | val pfn  wrdy rdv rdd tc rc
        tbl[0]  = mk(1, p42, 0, 0, 0,  0,   0, '0,  1,   0, 0,  0, 0);
        tbl[1]  = mk(0, '0,  0, 0, 0,  0,   1, p42, 1,   0, 0,  0, 0);
        tbl[2]  = mk(0, '0,  0, 0, 0,  0,   1, p42, 1,   0, 0,  0, 0);
        tbl[3]  = mk(0, '0,  0, 0, 0,  0,   1, p42, 1,   0, 0,  0, 0);
        tbl[4]  = mk(0, '0,  0, 0, 0,  0,   1, p42, 1,   0, 0,  0, 0);
        tbl[5]  = mk(0, '0,  0, 0, 0,  0,   1, p42, 1,   0, 0,  0, 0);
        tbl[6]  = mk(0, '0,  1, 0, 0,  0,   0, '0,  1,   0, 0,  1, 0);
        tbl[7]  = mk(0, '0,  1, 0, 0,  0,   0, '0,  1,   0, 0,  1, 0);
        tbl[8]  = mk(0, '0,  0, 0, 0,  0,   0, '0,  1,   0, 0,  1, 0);
        tbl[9]  = mk(0, '0,  0, 1, 69, 0,   0, '0,  1,   1, 69, 1, 1);
        tbl[10] = mk(0, '0,  0, 1, 69, 0,   0, '0,  1,   1, 69, 1, 1);
        tbl[11] = mk(0, '0,  0, 1, 69, 1,   0, '0,  1,   0, 0,  1, 1);
        tbl[12] = mk(0, '0,  0, 0, 0,  0,   0, '0,  1,   0, 0,  1, 1);

        // Reset state
        idle_inputs();
        rst = 1'b1;
        step();
        chk("rst pfn_valid", 32'(bus.Packet_From_Node_Valid), 32'd0);
        chk("rst pfn", 32'(bus.Packet_From_Node), 32'd0);
        chk("rst wr_ready", 32'(bus.Pe_Wr_Ready), 32'd1);
        chk("rst rd_valid", 32'(bus.Pe_Rd_Valid), 32'd0);
        chk("rst rd_data", 32'(bus.Pe_Rd_Data), 32'd0);
        chk("rst flags", {30'd0, tx_timeout, rx_overflow}, 32'd0);
        chk("rst counts", {16'd0, tx_count, rx_count}, 32'd0);
        rst = 1'b0;
        step();

        // Basic send and single inbound delivery
        for (int i = 0; i < 13; i++) begin
            bus.Pe_Wr_Valid          = tbl[i].wv;
            bus.Pe_Wr_Data           = tbl[i].wd;
            bus.Core_Load_Ack        = tbl[i].ack;
            bus.Packet_To_Node_Valid = tbl[i].pv;
            bus.Packet_To_Node       = tbl[i].pd;
            bus.Pe_Rd_Ready          = tbl[i].rr;
            step();
            chk($sformatf("v%0d pfn_valid", i), 32'(bus.Packet_From_Node_Valid), 32'(tbl[i].e_val));
            if (tbl[i].e_val)
                chk($sformatf("v%0d pfn", i), 32'(bus.Packet_From_Node), 32'(tbl[i].e_pfn));
            chk($sformatf("v%0d wr_ready", i), 32'(bus.Pe_Wr_Ready), 32'(tbl[i].e_wrdy));
            chk($sformatf("v%0d rd_valid", i), 32'(bus.Pe_Rd_Valid), 32'(tbl[i].e_rdv));
            if (tbl[i].e_rdv)
                chk($sformatf("v%0d rd_data", i), 32'(bus.Pe_Rd_Data), 32'(tbl[i].e_rdd));
            chk($sformatf("v%0d tx_count", i), 32'(tx_count), 32'(tbl[i].e_tc));
            chk($sformatf("v%0d rx_count", i), 32'(rx_count), 32'(tbl[i].e_rc));
            chk($sformatf("v%0d flags", i), {30'd0, tx_timeout, rx_overflow}, 32'd0);
        end

        // Inbound overflow: five deliveries into a four-entry queue
        for (int i = 0; i < 5; i++) begin
            bus.Packet_To_Node_Valid = 1'b1;
            bus.Packet_To_Node       = 24'(200 + i);
            step();
            bus.Packet_To_Node_Valid = 1'b0;
            step();
        end
        chk("ovf flag", 32'(rx_overflow), 32'd1);
        chk("ovf rx_count", 32'(rx_count), 32'd5);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ovf rd_valid%0d", i), 32'(bus.Pe_Rd_Valid), 32'd1);
            chk($sformatf("ovf rd_data%0d", i), 32'(bus.Pe_Rd_Data), 32'(200 + i));
            bus.Pe_Rd_Ready = 1'b1;
            step();
            bus.Pe_Rd_Ready = 1'b0;
        end
        chk("ovf drained", 32'(bus.Pe_Rd_Valid), 32'd0);

        // Push into a full inbound queue with a same-cycle pop is kept
        for (int i = 0; i < 5; i++) begin
            bus.Packet_To_Node_Valid = 1'b1;
            bus.Packet_To_Node       = 24'(300 + i);
            bus.Pe_Rd_Ready          = (i == 4);
            step();
            bus.Packet_To_Node_Valid = 1'b0;
            bus.Pe_Rd_Ready          = 1'b0;
            step();
        end
        chk("fullpop rx_count", 32'(rx_count), 32'd10);
        for (int i = 1; i < 5; i++) begin
            chk($sformatf("fullpop rd_data%0d", i), 32'(bus.Pe_Rd_Data), 32'(300 + i));
            bus.Pe_Rd_Ready = 1'b1;
            step();
            bus.Pe_Rd_Ready = 1'b0;
        end
        chk("fullpop drained", 32'(bus.Pe_Rd_Valid), 32'd0);

        // Level ack held across back-to-back packets
        do_reset();
        bus.Pe_Wr_Valid = 1'b1;
        bus.Pe_Wr_Data  = p42;
        step();
        bus.Pe_Wr_Data  = p100;
        step();
        bus.Pe_Wr_Valid = 1'b0;
        chk("lvl first offer", 32'(bus.Packet_From_Node), 32'(p42));
        bus.Core_Load_Ack = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            chk($sformatf("lvl hold valid%0d", c), 32'(bus.Packet_From_Node_Valid), 32'd0);
            chk($sformatf("lvl hold count%0d", c), 32'(tx_count), 32'd1);
        end
        bus.Core_Load_Ack = 1'b0;
        step();
        chk("lvl gap", 32'(bus.Packet_From_Node_Valid), 32'd0);
        wait_offer("lvl second offer");
        chk("lvl second pkt", 32'(bus.Packet_From_Node), 32'(p100));
        chk("lvl count before", 32'(tx_count), 32'd1);
        bus.Core_Load_Ack = 1'b1;
        step();
        bus.Core_Load_Ack = 1'b0;
        step();
        chk("lvl count end", 32'(tx_count), 32'd2);

        // Full outbound FIFO: fifth write refused, four drain in order
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bus.Pe_Wr_Valid = 1'b1;
            bus.Pe_Wr_Data  = make_pkt(4'(i), i[0], 24'(256 + i));
            step();
            if (i == 3)
                chk("full after 4", 32'(bus.Pe_Wr_Ready), 32'd0);
        end
        bus.Pe_Wr_Valid = 1'b0;
        chk("full after 5", 32'(bus.Pe_Wr_Ready), 32'd0);
        for (int k = 0; k < 4; k++) begin
            wait_offer($sformatf("full offer%0d", k));
            pk = make_pkt(4'(k), k[0], 24'(256 + k));
            chk($sformatf("full order%0d", k), 32'(bus.Packet_From_Node), 32'(pk));
            bus.Core_Load_Ack = 1'b1;
            step();
            bus.Core_Load_Ack = 1'b0;
            step();
        end
        for (int c = 0; c < 6; c++) step();
        chk("full fifth dropped", 32'(bus.Packet_From_Node_Valid), 32'd0);
        chk("full tx_count", 32'(tx_count), 32'd4);

        // Ack timeout with the offer held
        do_reset();
        bus.Pe_Wr_Valid = 1'b1;
        bus.Pe_Wr_Data  = p42;
        step();
        bus.Pe_Wr_Valid = 1'b0;
        wait_offer("tmo offer");
        for (int c = 0; c < 9; c++) step();
        chk("tmo before", 32'(tx_timeout), 32'd0);
        step();
        chk("tmo set", 32'(tx_timeout), 32'd1);
        chk("tmo valid held", 32'(bus.Packet_From_Node_Valid), 32'd1);
        chk("tmo data held", 32'(bus.Packet_From_Node), 32'(p42));

        // Reset mid-offer with an inbound entry queued
        do_reset();
        bus.Packet_To_Node_Valid = 1'b1;
        bus.Packet_To_Node       = 24'd7;
        bus.Pe_Wr_Valid          = 1'b1;
        bus.Pe_Wr_Data           = p100;
        step();
        bus.Packet_To_Node_Valid = 1'b0;
        bus.Pe_Wr_Valid          = 1'b0;
        wait_offer("rmo offer");
        #2 rst = 1'b1;
        #1 chk("rmo async drop", 32'(bus.Packet_From_Node_Valid), 32'd0);
        step();
        step();
        rst = 1'b0;
        step();
        chk("rmo rd_valid", 32'(bus.Pe_Rd_Valid), 32'd0);
        chk("rmo wr_ready", 32'(bus.Pe_Wr_Ready), 32'd1);
        step();
        step();
        chk("rmo no reoffer", 32'(bus.Packet_From_Node_Valid), 32'd0);

        // Randomized run against the reference model
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            model_compare(cyc);
            bus.Pe_Wr_Valid          = ($urandom_range(0, 99) < 50);
            bus.Pe_Wr_Data           = node_pkt_t'($urandom);
            bus.Core_Load_Ack        = ($urandom_range(0, 99) < 25);
            bus.Packet_To_Node_Valid = ($urandom_range(0, 99) < 50);
            bus.Packet_To_Node       = payload_t'($urandom);
            bus.Pe_Rd_Ready          = ($urandom_range(0, 99) < 30);
            model_edge();
            step();
        end
        model_compare(3000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
